burst_ack_tracker: RTL and testbench
====================================

BURST_ACK_TRACKER -- requirements
Module: burst_ack_tracker

Interface
REQ-001 SHALL have parameter START_DLY, default 2: sample edges from start sample to first countable ack sample.
REQ-002 SHALL have parameter MIN_ACKS, default 2: lowest accepted ack target.
REQ-003 SHALL have parameter MAX_ACKS, default 5: highest accepted ack target.
REQ-004 SHALL have parameter TIMEOUT, default 16: maximum consecutive COLLECT edges without an ack.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port transmiter, input, 1: burst start request.
REQ-008 SHALL have port recevier, input, 1: ack strobe; acks may be non-consecutive.
REQ-009 SHALL have port req_count, input, 3: number of acks expected, latched at start.
REQ-010 SHALL have port complete, output, 1: one-cycle burst-done pulse.
REQ-011 SHALL have port err, output, 1: one-cycle timeout pulse.
REQ-012 SHALL have port busy, output, 1: high while a burst is in progress.
REQ-013 SHALL have port ack_cnt, output, 3: acks counted in the current burst.

Function
REQ-014 SHALL implement states IDLE, DELAY, COLLECT and DONE.
REQ-015 In IDLE or DONE, transmiter=1 sampled at edge E0 SHALL go to DELAY, set busy=1, clear ack_cnt and latch the target.
REQ-016 Target SHALL be req_count clamped to MIN_ACKS..MAX_ACKS (0,1 -> 2; 6,7 -> 5).
REQ-017 Acks sampled at edges E0+1 .. E0+START_DLY-1 SHALL be ignored (DELAY).
REQ-018 State SHALL be COLLECT for sample edges E0+START_DLY onward; ack at exactly E0+START_DLY SHALL count.
REQ-019 In COLLECT, each edge sampling recevier=1 SHALL increment ack_cnt by 1; recevier=0 edges SHALL not count.
REQ-020 At edge EN, where ack_cnt reaches target, SHALL go to DONE with complete=1 and busy=0.
REQ-021 complete SHALL be high only for the cycle between EN and EN+1, so it samples 1 at EN+1.
REQ-022 Acks beyond target SHALL never be counted; ack_cnt saturates at target.
REQ-023 DONE SHALL last one cycle, then go to IDLE, or to DELAY if transmiter=1 at EN+1.
REQ-024 transmiter=1 in DELAY or COLLECT SHALL be ignored; there SHALL be no restart mid-burst.
REQ-025 recevier=1 in IDLE SHALL be ignored; ack_cnt holds its last value.
REQ-026 In COLLECT, TIMEOUT consecutive non-ack edges SHALL pulse err for one cycle, clear busy and return to IDLE.
REQ-027 The idle counter SHALL reset on every counted ack; complete and err SHALL never be high together.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from input to output.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, complete=0, err=0, busy=0, ack_cnt=0, and clear the latched target and timers.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no complete or err pulse.
REQ-031 After rst_n rises, the first start SHALL be accepted no earlier than the next rising clk edge.

Verification
REQ-032 Start at E0, req_count=2, ack at E0+2, gap at E0+3, ack at E0+4 -> complete=1 sampled at E0+5, ack_cnt=2, busy=0.
REQ-033 req_count=5, acks at E0+2..E0+6 consecutive -> complete at E0+7; extra ack at E0+7 leaves ack_cnt=5.
REQ-034 req_count=0 -> clamped target 2; req_count=7 -> target 5; check complete timing in both cases.
REQ-035 Ack at E0+1 only, then acks at E0+2 and E0+3 -> E0+1 ack ignored, complete at E0+4.
REQ-036 Start, then no ack for 16 COLLECT edges -> single err pulse, no complete, busy=0, state IDLE.
REQ-037 rst_n=0 between clk edges during COLLECT with ack_cnt=1 -> all outputs 0 at once; a new start after release gives a normal burst.

Source files
------------

// File: rtl/burst_ack_tracker.sv
// -----------------------------------------------------------------------------
// burst_ack_tracker
//
// Tracks one burst of acknowledgements. A start request latches a clamped ack
// target, waits a fixed number of sample edges, then counts ack strobes until
// the target is reached (one-cycle complete pulse) or until too many
// consecutive edges pass without an ack (one-cycle err pulse).
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   transmiter : burst start request (ignored while a burst is in progress)
//   recevier   : ack strobe, counted only while collecting
//   req_count  : requested ack count, latched and clamped at start
//   complete   : one-cycle pulse when the target ack count is reached
//   err        : one-cycle pulse when the collect phase times out
//   busy       : high while a burst is in progress
//   ack_cnt    : acks counted in the current (or last) burst
// -----------------------------------------------------------------------------
module burst_ack_tracker #(
  parameter int START_DLY = 2,
  parameter int MIN_ACKS  = 2,
  parameter int MAX_ACKS  = 5,
  parameter int TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       transmiter,
  input  logic       recevier,
  input  logic [2:0] req_count,
  output logic       complete,
  output logic       err,
  output logic       busy,
  output logic [2:0] ack_cnt
);

  // Delay counter holds START_DLY-1 at most; idle counter holds TIMEOUT-1 at most.
  localparam int DLY_W  = (START_DLY > 2) ? $clog2(START_DLY) : 1;
  localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0]        MIN_T     = 3'(MIN_ACKS);
  localparam logic [2:0]        MAX_T     = 3'(MAX_ACKS);
  localparam logic [DLY_W-1:0]  DLY_LOAD  = DLY_W'(START_DLY - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DELAY   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [DLY_W-1:0]    dly_r, dly_s;
  logic [IDLE_W-1:0]   idle_r, idle_s;
  logic [2:0]          tgt_r, tgt_s;
  logic [2:0]          cnt_r, cnt_s;
  logic                complete_r, complete_s;
  logic                err_r, err_s;
  logic                busy_r, busy_s;
  logic [2:0]          cnt_inc_s;

  // Clamp the requested ack count into the accepted target window.
  function automatic logic [2:0] clamp_target(input logic [2:0] req);
    logic [2:0] t;
    if (req < MIN_T) begin
      t = MIN_T;
    end else if (req > MAX_T) begin
      t = MAX_T;
    end else begin
      t = req;
    end
    return t;
  endfunction

  assign cnt_inc_s = cnt_r + 3'd1;

  // Next-state, counter and output-pulse decode.
  always_comb begin
    state_s    = state_r;
    dly_s      = dly_r;
    idle_s     = idle_r;
    tgt_s      = tgt_r;
    cnt_s      = cnt_r;
    complete_s = 1'b0;
    err_s      = 1'b0;
    busy_s     = busy_r;

    case (state_r)
      IDLE, DONE: begin
        if (transmiter) begin
          // With a one-edge (or zero) delay the very next edge already counts.
          if (START_DLY > 1) begin
            state_s = DELAY;
          end else begin
            state_s = COLLECT;
          end
          dly_s  = DLY_LOAD;
          idle_s = '0;
          tgt_s  = clamp_target(req_count);
          cnt_s  = 3'd0;
          busy_s = 1'b1;
        end else begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end
      end

      DELAY: begin
        // Acks here are deliberately dropped; only the delay count advances.
        if (dly_r <= DLY_W'(1)) begin
          state_s = COLLECT;
          idle_s  = '0;
        end else begin
          dly_s = dly_r - DLY_W'(1);
        end
      end

      COLLECT: begin
        if (recevier) begin
          idle_s = '0;
          if (cnt_r < tgt_r) begin
            cnt_s = cnt_inc_s;
          end else begin
            cnt_s = cnt_r;
          end
          if (cnt_inc_s >= tgt_r) begin
            state_s    = DONE;
            complete_s = 1'b1;
            busy_s     = 1'b0;
          end else begin
            state_s = COLLECT;
          end
        end else begin
          if (idle_r >= IDLE_LAST) begin
            state_s = IDLE;
            err_s   = 1'b1;
            busy_s  = 1'b0;
            idle_s  = '0;
          end else begin
            idle_s = idle_r + IDLE_W'(1);
          end
        end
      end

      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        idle_s  = '0;
        dly_s   = '0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      dly_r      <= '0;
      idle_r     <= '0;
      tgt_r      <= 3'd0;
      cnt_r      <= 3'd0;
      complete_r <= 1'b0;
      err_r      <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      dly_r      <= dly_s;
      idle_r     <= idle_s;
      tgt_r      <= tgt_s;
      cnt_r      <= cnt_s;
      complete_r <= complete_s;
      err_r      <= err_s;
      busy_r     <= busy_s;
    end
  end

  assign complete = complete_r;
  assign err      = err_r;
  assign busy     = busy_r;
  assign ack_cnt  = cnt_r;

endmodule

// File: tb/tb_burst_ack_tracker.sv
// -----------------------------------------------------------------------------
// Self-checking bench for burst_ack_tracker (default parameters).
// Inputs change on the falling edge; expectations are queued with the rising
// edge number after which they must hold and are compared on the following
// falling edge.
// -----------------------------------------------------------------------------
module tb_burst_ack_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       transmiter;
  logic       recevier;
  logic [2:0] req_count;
  logic       complete;
  logic       err;
  logic       busy;
  logic [2:0] ack_cnt;

  burst_ack_tracker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .transmiter (transmiter),
    .recevier   (recevier),
    .req_count  (req_count),
    .complete   (complete),
    .err        (err),
    .busy       (busy),
    .ack_cnt    (ack_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int         edge_n;
    string      tag;
    logic       c;
    logic       e;
    logic       b;
    logic [2:0] n;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int e, input string tag, input logic c, input logic er,
                      input logic b, input logic [2:0] n);
    exp_t x;
    x.edge_n = e; x.tag = tag; x.c = c; x.e = er; x.b = b; x.n = n;
    sb.push_back(x);
  endtask

  task automatic step(input logic tx, input logic rx, input logic [2:0] rq);
    transmiter = tx;
    recevier   = rx;
    req_count  = rq;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_complete"}, {7'd0, complete}, 8'd0);
    check_val({tag, "_err"},      {7'd0, err},      8'd0);
    check_val({tag, "_busy"},     {7'd0, busy},     8'd0);
    check_val({tag, "_ack_cnt"},  {5'd0, ack_cnt},  8'd0);
  endtask

  // Scoreboard monitor: compare every expectation due after the last edge.
  always @(negedge clk) begin : mon
    exp_t x;
    while (sb.size() > 0 && sb[0].edge_n == cyc) begin
      x = sb.pop_front();
      check_val({x.tag, "_complete"}, {7'd0, complete}, {7'd0, x.c});
      check_val({x.tag, "_err"},      {7'd0, err},      {7'd0, x.e});
      check_val({x.tag, "_busy"},     {7'd0, busy},     {7'd0, x.b});
      check_val({x.tag, "_ack_cnt"},  {5'd0, ack_cnt},  {5'd0, x.n});
    end
  end

  initial begin
    int e0;
    int e1;
    int t;
    rst_n      = 1'b0;
    transmiter = 1'b0;
    recevier   = 1'b0;
    req_count  = 3'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Gapped acks, mid-burst start ignored, restart from DONE, idle acks ignored.
    e0 = cyc + 1;
    e1 = e0 + 5;
    push(e0,     "s1_start",   1'b0, 1'b0, 1'b1, 3'd0);
    push(e0 + 1, "s1_delay",   1'b0, 1'b0, 1'b1, 3'd0);
    push(e0 + 2, "s1_ack1",    1'b0, 1'b0, 1'b1, 3'd1);
    push(e0 + 3, "s1_gap",     1'b0, 1'b0, 1'b1, 3'd1);
    push(e0 + 4, "s1_done",    1'b1, 1'b0, 1'b0, 3'd2);
    push(e1,     "s1_restart", 1'b0, 1'b0, 1'b1, 3'd0);
    push(e1 + 3, "s1b_two",    1'b0, 1'b0, 1'b1, 3'd2);
    push(e1 + 4, "s1b_done",   1'b1, 1'b0, 1'b0, 3'd3);
    push(e1 + 5, "s1b_after",  1'b0, 1'b0, 1'b0, 3'd3);
    push(e1 + 6, "idle_ack",   1'b0, 1'b0, 1'b0, 3'd3);
    step(1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b0, 3'd7);
    step(1'b0, 1'b1, 3'd0);
    step(1'b1, 1'b0, 3'd3);
    step(1'b0, 1'b0, 3'd0);
    repeat (3) step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b0, 3'd0);

    // Ack during the delay window must not count.
    e0 = cyc + 1;
    push(e0 + 1, "s2_early", 1'b0, 1'b0, 1'b1, 3'd0);
    push(e0 + 2, "s2_one",   1'b0, 1'b0, 1'b1, 3'd1);
    push(e0 + 3, "s2_done",  1'b1, 1'b0, 1'b0, 3'd2);
    step(1'b1, 1'b0, 3'd2);
    repeat (3) step(1'b0, 1'b1, 3'd0);
    repeat (2) step(1'b0, 1'b0, 3'd0);

    // Every req_count with continuous acks: clamped target, saturation in DONE.
    for (int rq = 0; rq < 8; rq++) begin
      t  = (rq < 2) ? 2 : ((rq > 5) ? 5 : rq);
      e0 = cyc + 1;
      push(e0 + t,     $sformatf("rq%0d_pre", rq),  1'b0, 1'b0, 1'b1, 3'(t - 1));
      push(e0 + t + 1, $sformatf("rq%0d_done", rq), 1'b1, 1'b0, 1'b0, 3'(t));
      push(e0 + t + 2, $sformatf("rq%0d_sat", rq),  1'b0, 1'b0, 1'b0, 3'(t));
      step(1'b1, 1'b0, 3'(rq));
      for (int k = 1; k <= t + 2; k++) step(1'b0, 1'b1, 3'd0);
      step(1'b0, 1'b0, 3'd0);
    end

    // Timeout after 16 silent collect edges.
    e0 = cyc + 1;
    push(e0 + 16, "to_pre",   1'b0, 1'b0, 1'b1, 3'd0);
    push(e0 + 17, "to_err",   1'b0, 1'b1, 1'b0, 3'd0);
    push(e0 + 18, "to_after", 1'b0, 1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd4);
    for (int k = 1; k <= 19; k++) step(1'b0, 1'b0, 3'd0);

    // A counted ack restarts the timeout window.
    e0 = cyc + 1;
    push(e0 + 10, "to2_ack",   1'b0, 1'b0, 1'b1, 3'd1);
    push(e0 + 25, "to2_pre",   1'b0, 1'b0, 1'b1, 3'd1);
    push(e0 + 26, "to2_err",   1'b0, 1'b1, 1'b0, 3'd1);
    push(e0 + 27, "to2_after", 1'b0, 1'b0, 1'b0, 3'd1);
    step(1'b1, 1'b0, 3'd4);
    for (int k = 1; k <= 28; k++) step(1'b0, (k == 10), 3'd0);

    // Asynchronous reset in the middle of collecting.
    e0 = cyc + 1;
    push(e0 + 2, "rst_pre", 1'b0, 1'b0, 1'b1, 3'd1);
    step(1'b1, 1'b0, 3'd3);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    check_all_zero("rst_held");
    rst_n = 1'b1;

    // Normal burst after reset release.
    e0 = cyc + 1;
    push(e0,     "post_start", 1'b0, 1'b0, 1'b1, 3'd0);
    push(e0 + 3, "post_done",  1'b1, 1'b0, 1'b0, 3'd2);
    push(e0 + 4, "post_idle",  1'b0, 1'b0, 1'b0, 3'd2);
    step(1'b1, 1'b0, 3'd2);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    step(1'b0, 1'b1, 3'd0);
    repeat (3) step(1'b0, 1'b0, 3'd0);

    check_val("sb_drain", 8'(sb.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
